cpu_ddr_bridge_arbiter: RTL and testbench



---
 rtl/cpu_ddr_bridge_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cpu_ddr_bridge_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ddr_bridge_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the CPU-to-DDR bridge slave port, with read-ID
// tracking. Define CPU_DDR_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (r0 > r1).
module cpu_ddr_bridge_arbiter #(
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned PW          = 4
) (
  input  logic        slave_clk,
  input  logic        slave_reset_n,

  input  logic [23:0] r0_address,
  input  logic [3:0]  r0_byteenable,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [31:0] r0_writedata,
  output logic        r0_waitrequest,
  output logic [31:0] r0_readdata,
  output logic        r0_readdatavalid,

  input  logic [23:0] r1_address,
  input  logic [3:0]  r1_byteenable,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [31:0] r1_writedata,
  output logic        r1_waitrequest,
  output logic [31:0] r1_readdata,
  output logic        r1_readdatavalid,

  output logic [23:0] br_address,
  output logic [3:0]  br_byteenable,
  output logic        br_read,
  output logic        br_write,
  output logic [31:0] br_writedata,
  input  logic        br_waitrequest,
  input  logic [31:0] br_readdata,
  input  logic        br_readdatavalid,

  output logic        err_unexpected_rdv
);

  localparam int unsigned AW = $clog2(MAX_PENDING);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          pend_cnt_q;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [MAX_PENDING-1:0] id_fifo_q;
  logic                   err_q;

  logic req0, req1, gnt0, gnt1, full, blk0, blk1, acc0, acc1;
  logic push, push_id, pend_nz, pop, head_id;
  logic idle_winner, sw0, sw1;

  assign req0 = r0_read | r0_write;
  assign req1 = r1_read | r1_write;
  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);
  assign full = (pend_cnt_q == PW'(MAX_PENDING));

  // A read at the pending limit is held back from the bridge until a slot frees.
  assign blk0 = gnt0 & r0_read & full;
  assign blk1 = gnt1 & r1_read & full;
  assign acc0 = gnt0 & req0 & ~br_waitrequest & ~blk0;
  assign acc1 = gnt1 & req1 & ~br_waitrequest & ~blk1;

  assign push    = (acc0 & r0_read) | (acc1 & r1_read);
  assign push_id = acc1;
  assign pend_nz = (pend_cnt_q != '0);
  assign pop     = br_readdatavalid & pend_nz;
  assign head_id = id_fifo_q[rd_ptr_q];

`ifdef CPU_DDR_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a tie the requester that did not win last goes next.
  assign idle_winner = (req0 & req1) ? ~last_q : req1;
  assign sw0 = req1;
  assign sw1 = req0;

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      last_q <= 1'b1;
    end else if (acc0) begin
      last_q <= 1'b0;
    end else if (acc1) begin
      last_q <= 1'b1;
    end
  end
`else
  assign idle_winner = ~req0;
  assign sw0 = 1'b0;
  assign sw1 = req0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) state_d = idle_winner ? GNT1 : GNT0;
      end
      GNT0: begin
        if (acc0) begin
          if (sw0) state_d = GNT1;
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (acc1) begin
          if (sw1) state_d = GNT0;
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    br_address     = '0;
    br_byteenable  = '0;
    br_read        = 1'b0;
    br_write       = 1'b0;
    br_writedata   = '0;
    r0_waitrequest = 1'b1;
    r1_waitrequest = 1'b1;
    case (state_q)
      GNT0: begin
        br_address     = r0_address;
        br_byteenable  = r0_byteenable;
        br_read        = r0_read & ~full;
        br_write       = r0_write;
        br_writedata   = r0_writedata;
        r0_waitrequest = blk0 | br_waitrequest;
      end
      GNT1: begin
        br_address     = r1_address;
        br_byteenable  = r1_byteenable;
        br_read        = r1_read & ~full;
        br_write       = r1_write;
        br_writedata   = r1_writedata;
        r1_waitrequest = blk1 | br_waitrequest;
      end
      default: ;
    endcase
  end

  assign r0_readdatavalid   = pop & ~head_id;
  assign r1_readdatavalid   = pop & head_id;
  assign r0_readdata        = br_readdata;
  assign r1_readdata        = br_readdata;
  assign err_unexpected_rdv = err_q;

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state_q    <= IDLE;
      pend_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_fifo_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        id_fifo_q[wr_ptr_q] <= push_id;
        wr_ptr_q            <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        pend_cnt_q <= pend_cnt_q + PW'(1);
      end else if (pop && !push) begin
        pend_cnt_q <= pend_cnt_q - PW'(1);
      end
      if (br_readdatavalid && !pend_nz) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ddr_bridge_arbiter.sv
// Randomized and directed bench for cpu_ddr_bridge_arbiter against a transaction-level model
// (owner, queue of pending read IDs, sticky error). Honours CPU_DDR_ARB_ROUND_ROBIN_EN.
module tb_cpu_ddr_bridge_arbiter;

  localparam int MaxPending = 8;

  logic        slave_clk, slave_reset_n;
  logic [23:0] r0_address, r1_address, br_address;
  logic [3:0]  r0_byteenable, r1_byteenable, br_byteenable;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata, br_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata, br_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic        br_read, br_write, br_waitrequest, br_readdatavalid;
  logic        err_unexpected_rdv;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner -1 none, else requester index; queue holds requester of each pending read.
  int m_owner;
  int m_ids[$];
  bit m_err, m_last, m_acc;

  cpu_ddr_bridge_arbiter #(.MAX_PENDING(8), .PW(4)) dut (
    .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
    .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
    .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
    .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .br_address(br_address), .br_byteenable(br_byteenable), .br_read(br_read),
    .br_write(br_write), .br_writedata(br_writedata), .br_waitrequest(br_waitrequest),
    .br_readdata(br_readdata), .br_readdatavalid(br_readdatavalid),
    .err_unexpected_rdv(err_unexpected_rdv)
  );

  initial slave_clk = 1'b0;
  always #5 slave_clk = ~slave_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit rd(input int n);
    return (n == 0) ? r0_read : r1_read;
  endfunction

  function automatic bit wr(input int n);
    return (n == 0) ? r0_write : r1_write;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ids.delete();
    m_err  = 1'b0;
    m_last = 1'b1;
    m_acc  = 1'b0;
  endtask

  task automatic clear_inputs();
    r0_address = '0; r0_byteenable = '0; r0_read = 0; r0_write = 0; r0_writedata = '0;
    r1_address = '0; r1_byteenable = '0; r1_read = 0; r1_write = 0; r1_writedata = '0;
    br_waitrequest = 0; br_readdata = '0; br_readdatavalid = 0;
  endtask

  task automatic check_outputs();
    bit full, blk, e_rd, e_wr, e_w0, e_w1, rdv_ok;
    int n, head;
    full = (m_ids.size() == MaxPending);
    e_rd = 0; e_wr = 0; e_w0 = 1; e_w1 = 1;
    if (m_owner >= 0) begin
      n    = m_owner;
      blk  = rd(n) && full;
      e_rd = rd(n) && !blk;
      e_wr = wr(n);
      if (n == 0) e_w0 = blk || br_waitrequest;
      else        e_w1 = blk || br_waitrequest;
      check("br_address", 32'(br_address), 32'((n == 0) ? r0_address : r1_address));
      check("br_byteenable", 32'(br_byteenable), 32'((n == 0) ? r0_byteenable : r1_byteenable));
      check("br_writedata", br_writedata, (n == 0) ? r0_writedata : r1_writedata);
    end
    check("br_read", 32'(br_read), 32'(e_rd));
    check("br_write", 32'(br_write), 32'(e_wr));
    check("r0_waitrequest", 32'(r0_waitrequest), 32'(e_w0));
    check("r1_waitrequest", 32'(r1_waitrequest), 32'(e_w1));
    rdv_ok = br_readdatavalid && (m_ids.size() > 0);
    head   = rdv_ok ? m_ids[0] : 0;
    check("r0_readdatavalid", 32'(r0_readdatavalid), 32'(rdv_ok && head == 0));
    check("r1_readdatavalid", 32'(r1_readdatavalid), 32'(rdv_ok && head == 1));
    if (rdv_ok) begin
      check("r0_readdata", r0_readdata, br_readdata);
      check("r1_readdata", r1_readdata, br_readdata);
    end
    check("err_unexpected_rdv", 32'(err_unexpected_rdv), 32'(m_err));
  endtask

  task automatic advance_model();
    bit full, blk, acc, q0, q1;
    int n;
    full = (m_ids.size() == MaxPending);
    q0 = r0_read | r0_write;
    q1 = r1_read | r1_write;
    acc = 0; n = 0;
    if (m_owner >= 0) begin
      n   = m_owner;
      blk = rd(n) && full;
      acc = (rd(n) || wr(n)) && !br_waitrequest && !blk;
    end
    if (br_readdatavalid) begin
      if (m_ids.size() > 0) void'(m_ids.pop_front());
      else m_err = 1'b1;
    end
    if (acc && rd(n)) m_ids.push_back(n);
    if (m_owner < 0) begin
      if (q0 || q1) begin
`ifdef CPU_DDR_ARB_ROUND_ROBIN_EN
        m_owner = (q0 && q1) ? (m_last ? 0 : 1) : (q0 ? 0 : 1);
`else
        m_owner = q0 ? 0 : 1;
`endif
      end
    end else if (acc) begin
`ifdef CPU_DDR_ARB_ROUND_ROBIN_EN
      m_last = (n == 1);
      if ((n == 0) ? q1 : q0) m_owner = 1 - n;
`else
      if (n == 1 && q0) m_owner = 0;
`endif
    end else if (!((n == 0) ? q0 : q1)) begin
      m_owner = -1;
    end
    m_acc = acc;
  endtask

  // Called at posedge+1 with inputs already set; checks mid-cycle, then advances one edge.
  task automatic step();
    #3;
    check_outputs();
    @(posedge slave_clk);
    advance_model();
    #1;
  endtask

  task automatic do_reset();
    slave_reset_n = 1'b0;
    clear_inputs();
    #2;
    model_reset();
    check_outputs();
    @(negedge slave_clk);
    slave_reset_n = 1'b1;
    @(posedge slave_clk);
    #1;
  endtask

  task automatic rand_inputs();
    int c0, c1;
    c0 = $urandom_range(0, 2);
    c1 = $urandom_range(0, 2);
    r0_read = (c0 == 1); r0_write = (c0 == 2);
    r1_read = (c1 == 1); r1_write = (c1 == 2);
    r0_address = 24'($urandom); r1_address = 24'($urandom);
    r0_byteenable = 4'($urandom); r1_byteenable = 4'($urandom);
    r0_writedata = $urandom; r1_writedata = $urandom;
    br_waitrequest   = ($urandom_range(0, 3) == 0);
    br_readdatavalid = (m_ids.size() > 0) && ($urandom_range(0, 2) == 0);
    br_readdata      = $urandom;
  endtask

  initial begin
    bit done;
    slave_reset_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    check_outputs();
    @(posedge slave_clk);
    #1;
    do_reset();

    // Single read with the bridge ready, then its return.
    r0_read = 1; r0_address = 24'h000100; r0_byteenable = 4'hf;
    step();
    step();
    check("single_read_acc", 32'(m_acc), 32'd1);
    r0_read = 0; br_readdatavalid = 1; br_readdata = 32'hDEADBEEF;
    step();
    br_readdatavalid = 0;
    step();

    // Both requesters stream writes, bridge never stalls.
    r0_write = 1; r1_write = 1;
    for (int i = 0; i < 8; i++) begin
      r0_writedata = $urandom; r1_writedata = $urandom;
      r0_address = 24'($urandom); r1_address = 24'($urandom);
      step();
    end
    clear_inputs();
    step();
    step();

    // Stall hold on an r1 write with r0 also requesting.
    r1_write = 1; r1_writedata = 32'h12345678; r1_address = 24'h00abcd; r1_byteenable = 4'h3;
    step();
    br_waitrequest = 1; r0_write = 1; r0_writedata = 32'h55aa55aa;
    for (int i = 0; i < 5; i++) step();
    br_waitrequest = 0;
    step();
    r1_write = 0;
    step();
    step();
    clear_inputs();
    step();
    step();

    // Fill the pending limit with alternating r0/r1 reads.
    for (int i = 0; i < MaxPending; i++) begin
      r0_read = (i % 2 == 0); r1_read = (i % 2 == 1);
      r0_address = 24'($urandom); r1_address = 24'($urandom);
      done = 0;
      for (int t = 0; t < 6 && !done; t++) begin
        step();
        done = m_acc;
      end
      check("issue_timeout", 32'(done), 32'd1);
      r0_read = 0; r1_read = 0;
    end
    r0_read = 1; r0_address = 24'h000900;
    for (int i = 0; i < 3; i++) step();
    done = 0;
    for (int t = 0; t < 20 && m_ids.size() > 0; t++) begin
      br_readdatavalid = 1; br_readdata = $urandom;
      step();
      if (m_acc) begin
        r0_read = 0;
        done = 1;
      end
    end
    br_readdatavalid = 0; r0_read = 0;
    check("ninth_read_accepted", 32'(done), 32'd1);
    check("drain_timeout", 32'(m_ids.size()), 32'd0);
    step();

    // Randomized traffic, then a reset with reads in flight.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      step();
    end
    clear_inputs();
    for (int t = 0; t < 20 && m_ids.size() > 0; t++) begin
      br_readdatavalid = 1;
      step();
    end
    br_readdatavalid = 0;
    step();

    // Spurious return: sticky error until reset.
    br_readdatavalid = 1; br_readdata = 32'hbad0bad0;
    step();
    br_readdatavalid = 0;
    for (int i = 0; i < 3; i++) step();
    check("err_sticky", 32'(err_unexpected_rdv), 32'd1);
    do_reset();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
